// File: rtl/pack_sync_pkg.sv
// Shared constants and types for the preamble synchroniser family.
// The reference preamble and pipeline sizing helpers live here.
package pack_sync_pkg;

  localparam logic [127:0] PREAMBLE_128 = 128'h3A5F_C196_0E7B_D248_95C3_6AF1_07DE_B42C;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  function automatic int acc_width(input int prea_len);
    return $clog2(prea_len) + 2;
  endfunction

  // Window register + adder tree stages + output register
  function automatic int latency(input int prea_len);
    return $clog2(prea_len) + 2;
  endfunction

endpackage

// File: rtl/pack_sync_if.sv
// Symbol stream bundle between the demodulator, pack_sync and the deinterleaver.
// master drives the soft symbols in; slave is the synchroniser itself.
interface pack_sync_if #(
  parameter int DW    = 5,
  parameter int LEN_W = 16,
  parameter int ACC_W = 9
);
  logic [DW-1:0]           idat;
  logic                    ival;
  logic [LEN_W-1:0]        ipay_len;
  logic [DW-1:0]           odat;
  logic                    oval;
  logic                    osop;
  logic                    oeop;
  logic                    oinv;
  logic                    olock;
  logic signed [ACC_W-1:0] ocorr;

  modport master (
    output idat, ival, ipay_len,
    input  odat, oval, osop, oeop, oinv, olock, ocorr
  );

  modport slave (
    input  idat, ival, ipay_len,
    output odat, oval, osop, oeop, oinv, olock, ocorr
  );
endinterface

// File: rtl/pack_sync_corr_tree.sv
// Pipelined +/-1 correlation adder tree: N match bits in, signed sum out after log2(N) clocks.
// The tree advances every clock; a valid bit rides alongside each slot.
module corr_tree #(
  parameter int N     = 128,
  parameter int ACC_W = $clog2(N) + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vld,
  input  logic [N-1:0]            match,
  output logic                    out_vld,
  output logic signed [ACC_W-1:0] corr
);
  localparam int STAGES = $clog2(N);

  // Every level is carried at ACC_W bits; level s only ever needs s+3 of them,
  // so each addition is effectively a one-bit sign extension and never overflows.
  logic signed [ACC_W-1:0] sum_d [STAGES][N/2];
  logic signed [ACC_W-1:0] sum_q [STAGES][N/2];
  logic [STAGES-1:0]       vld_d;
  logic [STAGES-1:0]       vld_q;

  function automatic logic signed [ACC_W-1:0] pm1(input logic b);
    return {{(ACC_W-1){~b}}, 1'b1};
  endfunction

  always_comb begin
    vld_d = {vld_q[STAGES-2:0], in_vld};
    for (int s = 0; s < STAGES; s++) begin
      for (int j = 0; j < N/2; j++) begin
        sum_d[s][j] = '0;
      end
    end
    for (int j = 0; j < N/2; j++) begin
      sum_d[0][j] = pm1(match[2*j]) + pm1(match[2*j+1]);
    end
    for (int s = 1; s < STAGES; s++) begin
      for (int j = 0; j < N/4; j++) begin
        if (j < (N >> (s+1))) begin
          sum_d[s][j] = sum_q[s-1][2*j] + sum_q[s-1][2*j+1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        for (int j = 0; j < N/2; j++) begin
          sum_q[s][j] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      sum_q <= sum_d;
    end
  end

  assign out_vld = vld_q[STAGES-1];
  assign corr    = sum_q[STAGES-1][0];

endmodule

// File: rtl/pack_sync.sv
// Preamble synchroniser/framer: sliding-window correlation, lock, then one framed payload burst.
// Symbol in to symbol out is log2(PREA_LEN)+2 clocks regardless of ival gaps.
module pack_sync
  import pack_sync_pkg::*;
#(
  parameter int                  DW       = 5,
  parameter int                  PREA_LEN = 128,
  parameter logic [PREA_LEN-1:0] PREAMBLE = PREA_LEN'(PREAMBLE_128),
  parameter int                  BORDER   = 80,
  parameter bit                  INV_EN   = 1'b1,
  parameter int                  PAY_LEN  = 1024,
  parameter int                  LEN_W    = 16,
  parameter int                  ACC_W    = acc_width(PREA_LEN)
) (
  input logic        iclk,
  input logic        irst,
  pack_sync_if.slave bus
);
  localparam int STAGES = $clog2(PREA_LEN);
  localparam int FILL_W = $clog2(PREA_LEN) + 1;
  localparam logic signed [ACC_W-1:0] POS_TH = ACC_W'(BORDER);
  localparam logic signed [ACC_W-1:0] NEG_TH = ACC_W'(-BORDER);

  logic [PREA_LEN-1:0]     window_d, window_q;
  logic [FILL_W-1:0]       fill_d, fill_q;
  logic                    win_vld_d, win_vld_q;
  logic                    armed;
  logic [DW:0]             dly_d [STAGES+1];
  logic [DW:0]             dly_q [STAGES+1];
  logic [PREA_LEN-1:0]     match;
  logic                    slot_vld;
  logic signed [ACC_W-1:0] slot_corr;
  logic [DW-1:0]           slot_dat;
  logic                    slot_armed;

  // Window shifts only on accepted symbols; bit 0 is the oldest.
  // A symbol is "armed" once the window has been completely refilled since reset.
  always_comb begin
    window_d  = window_q;
    fill_d    = fill_q;
    win_vld_d = bus.ival;
    if (bus.ival) begin
      window_d = {~bus.idat[DW-1], window_q[PREA_LEN-1:1]};
      if (fill_q != FILL_W'(PREA_LEN)) begin
        fill_d = fill_q + 1'b1;
      end
    end
    armed    = (fill_d == FILL_W'(PREA_LEN));
    dly_d[0] = {armed, bus.idat};
    for (int i = 1; i <= STAGES; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      window_q  <= '0;
      fill_q    <= '0;
      win_vld_q <= 1'b0;
      for (int i = 0; i <= STAGES; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      window_q  <= window_d;
      fill_q    <= fill_d;
      win_vld_q <= win_vld_d;
      dly_q     <= dly_d;
    end
  end

  assign match = ~(window_q ^ PREAMBLE);

  corr_tree #(
    .N     (PREA_LEN),
    .ACC_W (ACC_W)
  ) u_corr_tree (
    .clk     (iclk),
    .rst_n   (irst),
    .in_vld  (win_vld_q),
    .match   (match),
    .out_vld (slot_vld),
    .corr    (slot_corr)
  );

  assign slot_dat   = dly_q[STAGES][DW-1:0];
  assign slot_armed = dly_q[STAGES][DW];

  state_e                  state_d, state_q;
  logic                    inv_d, inv_q;
  logic [LEN_W-1:0]        len_d, len_q, len_sel;
  logic [LEN_W-1:0]        cnt_d, cnt_q;
  logic [DW-1:0]           odat_d, odat_q;
  logic                    oval_d, oval_q, osop_d, osop_q, oeop_d, oeop_q;
  logic                    oinv_d, oinv_q, olock_d, olock_q;
  logic signed [ACC_W-1:0] ocorr_d, ocorr_q;

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    odat_d  = '0;
    oval_d  = 1'b0;
    osop_d  = 1'b0;
    oeop_d  = 1'b0;
    olock_d = (state_q == PAYLOAD);
    oinv_d  = (state_q == PAYLOAD) && inv_q;
    ocorr_d = slot_vld ? slot_corr : ocorr_q;
    len_sel = (bus.ipay_len == '0) ? LEN_W'(PAY_LEN) : bus.ipay_len;
    case (state_q)
      SEARCH: begin
        if (slot_vld && slot_armed) begin
          if (slot_corr >= POS_TH) begin
            state_d = PAYLOAD;
            inv_d   = 1'b0;
            len_d   = len_sel;
            cnt_d   = '0;
          end else if (INV_EN && (slot_corr <= NEG_TH)) begin
            state_d = PAYLOAD;
            inv_d   = 1'b1;
            len_d   = len_sel;
            cnt_d   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (slot_vld) begin
          oval_d = 1'b1;
          odat_d = slot_dat ^ {inv_q, {(DW-1){1'b0}}};
          osop_d = (cnt_q == '0);
          oeop_d = (cnt_q == len_q - 1'b1);
          cnt_d  = cnt_q + 1'b1;
          if (oeop_d) begin
            state_d = SEARCH;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_q <= SEARCH;
      inv_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      odat_q  <= '0;
      oval_q  <= 1'b0;
      osop_q  <= 1'b0;
      oeop_q  <= 1'b0;
      oinv_q  <= 1'b0;
      olock_q <= 1'b0;
      ocorr_q <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      odat_q  <= odat_d;
      oval_q  <= oval_d;
      osop_q  <= osop_d;
      oeop_q  <= oeop_d;
      oinv_q  <= oinv_d;
      olock_q <= olock_d;
      ocorr_q <= ocorr_d;
    end
  end

  assign bus.odat  = odat_q;
  assign bus.oval  = oval_q;
  assign bus.osop  = osop_q;
  assign bus.oeop  = oeop_q;
  assign bus.oinv  = oinv_q;
  assign bus.olock = olock_q;
  assign bus.ocorr = ocorr_q;

endmodule

// File: tb/tb_pack_sync.sv
// Directed bench for pack_sync: normal/inverted lock, threshold edges, gaps, short bursts, mid-burst reset.
// A second instance with inversion disabled shares the input stream.
module tb_pack_sync;
  import pack_sync_pkg::*;

  localparam int LAT = 9;

  logic iclk = 1'b0;
  logic irst = 1'b0;
  int   cyc  = 0;

  pack_sync_if #(.DW(5), .LEN_W(16), .ACC_W(9)) bus ();
  pack_sync_if #(.DW(5), .LEN_W(16), .ACC_W(9)) bus_ni ();

  assign bus_ni.idat     = bus.idat;
  assign bus_ni.ival     = bus.ival;
  assign bus_ni.ipay_len = bus.ipay_len;

  pack_sync #(.INV_EN(1'b1)) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  pack_sync #(.INV_EN(1'b0)) dut_ni (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus_ni)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] dat;
    logic       sop;
    logic       eop;
    logic       inv;
    logic       lock;
    int         cyc;
  } rx_t;

  typedef struct {
    logic [4:0] dat;
    int         cyc;
  } exp_t;

  rx_t  rx[$];
  exp_t exp_q[$];
  int   ni_cnt = 0;
  logic eop_prev = 1'b0;
  logic lock_after_eop = 1'b1;
  bit   gap_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge iclk) begin
    if (bus.oval) rx.push_back('{bus.odat, bus.osop, bus.oeop, bus.oinv, bus.olock, cyc});
    if (bus_ni.oval) ni_cnt <= ni_cnt + 1;
    if (eop_prev) lock_after_eop <= bus.olock;
    eop_prev <= bus.oval & bus.oeop;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  function automatic logic [4:0] bit_sym(input logic b);
    logic [3:0] mag;
    mag = 4'($urandom);
    return {~b, mag};
  endfunction

  task automatic send_sym(input logic [4:0] d, input bit is_pay);
    if (gap_en) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.ival = 1'b0;
        @(posedge iclk); #1;
      end
    end
    bus.idat = d;
    bus.ival = 1'b1;
    if (is_pay) exp_q.push_back('{d, cyc});
    @(posedge iclk); #1;
    bus.ival = 1'b0;
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) send_sym(bit_sym(1'($urandom)), 1'b0);
  endtask

  task automatic send_pre(input logic [127:0] flip);
    logic [127:0] p;
    p = PREAMBLE_128 ^ flip;
    for (int k = 0; k < 128; k++) send_sym(bit_sym(p[k]), 1'b0);
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) send_sym(5'($urandom), 1'b1);
  endtask

  task automatic idle(input int n);
    bus.ival = 1'b0;
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic do_reset();
    bus.ival = 1'b0;
    irst = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    irst = 1'b1;
  endtask

  task automatic verify_burst(input string tag, input int rx_base, input int exp_base,
                              input int n, input int len, input bit inv);
    int got_n, d_err, se_err, f_err, l_err;
    got_n = rx.size() - rx_base;
    d_err = 0; se_err = 0; f_err = 0; l_err = 0;
    check_eq({tag, "_count"}, got_n, n);
    for (int i = 0; i < n && i < got_n; i++) begin
      rx_t  r;
      exp_t e;
      r = rx[rx_base + i];
      e = exp_q[exp_base + i];
      if (r.dat !== (e.dat ^ {inv, 4'b0000})) d_err++;
      if (r.sop !== ((i % len) == 0) || r.eop !== ((i % len) == len - 1)) se_err++;
      if (r.inv !== inv || r.lock !== 1'b1) f_err++;
      if (r.cyc - e.cyc != LAT) l_err++;
    end
    check_eq({tag, "_data_err"}, d_err, 0);
    check_eq({tag, "_sop_eop_err"}, se_err, 0);
    check_eq({tag, "_inv_lock_err"}, f_err, 0);
    check_eq({tag, "_latency_err"}, l_err, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int rx1, ex1, rxb, exb, nib, eops;
    logic [127:0] m;

    bus.idat = '0;
    bus.ival = 1'b0;
    bus.ipay_len = '0;
    repeat (3) @(posedge iclk);
    #1;
    check_eq("rst_oval_osop_oeop", {bus.oval, bus.osop, bus.oeop}, 0);
    check_eq("rst_oinv_olock", {bus.oinv, bus.olock}, 0);
    check_eq("rst_odat_ocorr", {bus.odat, bus.ocorr}, 0);
    irst = 1'b1;

    // Continuous stream, default payload length
    rx1 = rx.size(); ex1 = exp_q.size(); nib = ni_cnt;
    send_rand_bits(40);
    send_pre('0);
    send_payload(1024);
    send_rand_bits(16);
    idle(20);
    verify_burst("cont", rx1, ex1, 1024, 1024, 1'b0);
    check_eq("cont_lock_after_eop", lock_after_eop, 0);
    check_eq("cont_noinv_inst_count", ni_cnt - nib, 1024);

    // Inverted preamble
    do_reset();
    rxb = rx.size(); exb = exp_q.size(); nib = ni_cnt;
    send_rand_bits(40);
    send_pre('1);
    send_payload(1024);
    idle(20);
    verify_burst("inv", rxb, exb, 1024, 1024, 1'b1);
    check_eq("inv_noinv_inst_count", ni_cnt - nib, 0);

    // Threshold: 24 errors -> corr 80 locks
    do_reset();
    bus.ipay_len = 16'd4;
    m = '0;
    for (int i = 0; i < 24; i++) m[5*i] = 1'b1;
    rxb = rx.size(); exb = exp_q.size();
    send_rand_bits(20);
    send_pre(m);
    idle(15);
    check_eq("err24_ocorr", 32'($signed(bus.ocorr)), 80);
    check_eq("err24_olock", bus.olock, 1);
    send_payload(4);
    idle(20);
    verify_burst("err24", rxb, exb, 4, 4, 1'b0);

    // Threshold: 25 errors -> corr 78 does not lock
    do_reset();
    m[5*24] = 1'b1;
    rxb = rx.size();
    send_rand_bits(20);
    send_pre(m);
    idle(15);
    check_eq("err25_ocorr", 32'($signed(bus.ocorr)), 78);
    check_eq("err25_olock", bus.olock, 0);
    send_rand_bits(4);
    idle(20);
    check_eq("err25_count", rx.size() - rxb, 0);

    // Gapped input, same payload as the continuous run
    do_reset();
    bus.ipay_len = '0;
    gap_en = 1'b1;
    rxb = rx.size(); exb = exp_q.size();
    send_rand_bits(40);
    send_pre('0);
    for (int i = 0; i < 1024; i++) send_sym(exp_q[ex1 + i].dat, 1'b1);
    gap_en = 1'b0;
    idle(20);
    verify_burst("gap", rxb, exb, 1024, 1024, 1'b0);
    begin
      int diff;
      diff = 0;
      for (int i = 0; i < 1024 && rxb + i < rx.size(); i++)
        if (rx[rxb + i].dat !== rx[rx1 + i].dat) diff++;
      check_eq("gap_vs_cont_diff", diff, 0);
    end

    // Short bursts back to back
    do_reset();
    bus.ipay_len = 16'd3;
    rxb = rx.size(); exb = exp_q.size();
    send_rand_bits(10);
    send_pre('0);
    send_payload(3);
    send_pre('0);
    send_payload(3);
    idle(20);
    verify_burst("b2b", rxb, exb, 6, 3, 1'b0);

    // Preamble embedded in a payload does not re-trigger
    bus.ipay_len = 16'd200;
    rxb = rx.size(); exb = exp_q.size();
    send_rand_bits(10);
    send_pre('0);
    send_payload(20);
    begin
      logic [127:0] p;
      p = PREAMBLE_128;
      for (int k = 0; k < 128; k++) send_sym(bit_sym(p[k]), 1'b1);
    end
    send_payload(52);
    send_rand_bits(10);
    idle(20);
    verify_burst("embed", rxb, exb, 200, 200, 1'b0);

    // Single-symbol burst
    bus.ipay_len = 16'd1;
    rxb = rx.size(); exb = exp_q.size();
    send_pre('0);
    send_payload(1);
    send_rand_bits(4);
    idle(20);
    verify_burst("len1", rxb, exb, 1, 1, 1'b0);

    // Reset in the middle of a long burst
    do_reset();
    bus.ipay_len = '0;
    rxb = rx.size();
    send_rand_bits(10);
    send_pre('0);
    send_payload(500);
    irst = 1'b0;
    #1;
    check_eq("midrst_outputs",
             {bus.odat, bus.oval, bus.osop, bus.oeop, bus.oinv, bus.olock, bus.ocorr}, 0);
    @(posedge iclk); #1;
    irst = 1'b1;
    idle(20);
    eops = 0;
    for (int i = rxb; i < rx.size(); i++) if (rx[i].eop) eops++;
    check_eq("midrst_no_eop", eops, 0);
    check_eq("midrst_olock", bus.olock, 0);
    bus.ipay_len = 16'd3;
    rxb = rx.size(); exb = exp_q.size();
    send_pre('0);
    send_payload(3);
    idle(20);
    verify_burst("postrst", rxb, exb, 3, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
